// File: rtl/bfloat8_argmax_sequencer.sv
// Streaming bfloat8 argmax: one class score per beat, emits argmax index and max score per frame.
// Defining BF8_ARGMAX_RUNNER_UP_EN adds runner_up_idx/runner_up_score outputs.
module bfloat8_argmax_sequencer #(
  parameter int N_CLASSES = 10,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [IDX_W-1:0] prediction,
  output logic [7:0]       final_computation,
  output logic             frame_err,
`ifdef BF8_ARGMAX_RUNNER_UP_EN
  output logic [IDX_W-1:0] runner_up_idx,
  output logic [7:0]       runner_up_score,
`endif
  output logic             busy
);

  typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);
  // All-ones never names a real class, so it doubles as "no runner-up yet".
  localparam logic [IDX_W-1:0] NO_IDX   = '1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [7:0]       max_q, max_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] prediction_q, prediction_d;
  logic [7:0]       final_q, final_d;
  logic             frame_err_q, frame_err_d;
  logic             accept, last_beat, frame_end, new_max;

  // Sign-magnitude order mapped onto signed integers; 8'h00 and 8'h80 both map to 0.
  function automatic logic bf8_gt(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] ka, kb;
    ka = a[7] ? -$signed({2'b00, a[6:0]}) : $signed({2'b00, a[6:0]});
    kb = b[7] ? -$signed({2'b00, b[6:0]}) : $signed({2'b00, b[6:0]});
    return ka > kb;
  endfunction

  assign accept    = s_valid && s_ready && !flush;
  assign last_beat = (cnt_q == LAST_IDX);
  assign frame_end = accept && (last_beat || s_last);
  assign new_max   = (cnt_q == '0) || bf8_gt(s_data, max_q);

  // FSM state register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= COLLECT;
    else          state_q <= state_d;
  end

  // FSM next state; flush always returns to COLLECT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (frame_end)           state_d = DONE;
      DONE:    if (flush || m_ready)    state_d = COLLECT;
      default:                          state_d = COLLECT;
    endcase
  end

  // FSM outputs
  always_comb begin
    s_ready = (state_q == COLLECT);
    m_valid = (state_q == DONE);
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d        = cnt_q;
    max_d        = max_q;
    idx_d        = idx_q;
    prediction_d = prediction_q;
    final_d      = final_q;
    frame_err_d  = frame_err_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept) begin
      if (new_max) begin
        max_d = s_data;
        idx_d = cnt_q;
      end
      cnt_d = frame_end ? '0 : cnt_q + 1'b1;
      if (frame_end) begin
        prediction_d = idx_d;
        final_d      = max_d;
        frame_err_d  = (s_last != last_beat);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      max_q        <= 8'h00;
      idx_q        <= '0;
      prediction_q <= '1;
      final_q      <= 8'h00;
      frame_err_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      max_q        <= max_d;
      idx_q        <= idx_d;
      prediction_q <= prediction_d;
      final_q      <= final_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign prediction        = prediction_q;
  assign final_computation = final_q;
  assign frame_err         = frame_err_q;
  assign busy              = (cnt_q != '0) || m_valid;

`ifdef BF8_ARGMAX_RUNNER_UP_EN
  logic [IDX_W-1:0] ru_idx_q, ru_idx_d, ru_out_idx_q, ru_out_idx_d;
  logic [7:0]       ru_score_q, ru_score_d, ru_out_score_q, ru_out_score_d;

  // A new max demotes the old one; otherwise a beat displaces the runner-up only if strictly larger.
  always_comb begin
    ru_idx_d       = ru_idx_q;
    ru_score_d     = ru_score_q;
    ru_out_idx_d   = ru_out_idx_q;
    ru_out_score_d = ru_out_score_q;
    if (accept) begin
      if (cnt_q == '0) begin
        ru_idx_d   = NO_IDX;
        ru_score_d = 8'h00;
      end else if (new_max) begin
        ru_idx_d   = idx_q;
        ru_score_d = max_q;
      end else if (ru_idx_q == NO_IDX || bf8_gt(s_data, ru_score_q)) begin
        ru_idx_d   = cnt_q;
        ru_score_d = s_data;
      end
      if (frame_end) begin
        ru_out_idx_d   = ru_idx_d;
        ru_out_score_d = ru_score_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ru_idx_q       <= NO_IDX;
      ru_score_q     <= 8'h00;
      ru_out_idx_q   <= NO_IDX;
      ru_out_score_q <= 8'h00;
    end else begin
      ru_idx_q       <= ru_idx_d;
      ru_score_q     <= ru_score_d;
      ru_out_idx_q   <= ru_out_idx_d;
      ru_out_score_q <= ru_out_score_d;
    end
  end

  assign runner_up_idx   = ru_out_idx_q;
  assign runner_up_score = ru_out_score_q;
`endif

endmodule
